decoder_8b10b: RTL and testbench

- Receive-side 8b/10b decoder; counterpart of the encoder block.
- Accepts one 10-bit code group per enabled clock and returns the 8-bit byte plus control flag K.
- Tracks running disparity, flags code and disparity errors, and keeps a comma-based sync state machine.
- Sits after the serial-to-parallel stage and before the 8-bit-to-wide stage on the receive path.

---
 rtl/decoder_8b10b.sv | 251 +++++++++++++++++++++++++
 tb/tb_decoder_8b10b.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_8b10b.sv
// Receive-side 8b/10b decoder: 5b/6b + 3b/4b table decode, running-disparity
// tracking, code/disparity error flags and a comma-driven sync state machine.
module decoder_8b10b #(
    parameter int unsigned ERR_LIM   = 4,
    parameter int unsigned ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enb,
    input  logic [9:0]           entradas,
    output logic [7:0]           salidas,
    output logic                 K,
    output logic                 valido,
    output logic                 errCodigo,
    output logic                 errDisparidad,
    output logic                 rd,
    output logic                 sincronizado,
    output logic [ERR_CNT_W-1:0] cuentaErr
);
    localparam int unsigned CONS_W = 4;
    localparam logic [9:0] COMMA_N = 10'b0011111010;
    localparam logic [9:0] COMMA_P = 10'b1100000101;

    typedef enum logic {DESINC = 1'b0, SINC = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CONS_W-1:0]   cons_q, cons_d;
    logic [ERR_CNT_W-1:0] cnt_d;
    logic [7:0]          salidas_d;
    logic                k_d, valido_d, errc_d, errd_d, rd_d;

    logic [5:0] s6;
    logic [3:0] s4, c4;
    logic [4:0] x;
    logic [2:0] y4, ky;
    logic       v6, k28, v4, p7, a7, vk;
    logic       grp_lo, grp_hi, grp_k;
    logic       code_ok, dec_k;
    logic [7:0] dec_byte;
    logic [2:0] ones6, ones4;
    logic       e6, e4, rd1, rd2, disp_err;
    logic       comma, sym_err;

    assign s6    = entradas[9:4];
    assign s4    = entradas[3:0];
    assign ones6 = 3'($countones(s6));
    assign ones4 = 3'($countones(s4));
    assign comma = (entradas == COMMA_N) || (entradas == COMMA_P);
    // K28 neutral 3b/4b forms depend on the 6b polarity; fold the RD+ form onto RD-.
    assign c4    = (s6 == 6'b110000) ? ~s4 : s4;

    // 5b/6b decode, both polarities
    always_comb begin : dec6
        x   = 5'd0;
        v6  = 1'b1;
        k28 = 1'b0;
        case (s6)
            6'b100111, 6'b011000: x = 5'd0;
            6'b011101, 6'b100010: x = 5'd1;
            6'b101101, 6'b010010: x = 5'd2;
            6'b110001:            x = 5'd3;
            6'b110101, 6'b001010: x = 5'd4;
            6'b101001:            x = 5'd5;
            6'b011001:            x = 5'd6;
            6'b111000, 6'b000111: x = 5'd7;
            6'b111001, 6'b000110: x = 5'd8;
            6'b100101:            x = 5'd9;
            6'b010101:            x = 5'd10;
            6'b110100:            x = 5'd11;
            6'b001101:            x = 5'd12;
            6'b101100:            x = 5'd13;
            6'b011100:            x = 5'd14;
            6'b010111, 6'b101000: x = 5'd15;
            6'b011011, 6'b100100: x = 5'd16;
            6'b100011:            x = 5'd17;
            6'b010011:            x = 5'd18;
            6'b110010:            x = 5'd19;
            6'b001011:            x = 5'd20;
            6'b101010:            x = 5'd21;
            6'b011010:            x = 5'd22;
            6'b111010, 6'b000101: x = 5'd23;
            6'b110011, 6'b001100: x = 5'd24;
            6'b100110:            x = 5'd25;
            6'b010110:            x = 5'd26;
            6'b110110, 6'b001001: x = 5'd27;
            6'b001110:            x = 5'd28;
            6'b101110, 6'b010001: x = 5'd29;
            6'b011110, 6'b100001: x = 5'd30;
            6'b101011, 6'b010100: x = 5'd31;
            6'b001111, 6'b110000: begin x = 5'd28; k28 = 1'b1; end
            default:              v6 = 1'b0;
        endcase
    end

    // 3b/4b decode for data symbols
    always_comb begin : dec4
        y4 = 3'd0;
        v4 = 1'b1;
        p7 = 1'b0;
        a7 = 1'b0;
        case (s4)
            4'b1011, 4'b0100: y4 = 3'd0;
            4'b1001:          y4 = 3'd1;
            4'b0101:          y4 = 3'd2;
            4'b1100, 4'b0011: y4 = 3'd3;
            4'b1101, 4'b0010: y4 = 3'd4;
            4'b1010:          y4 = 3'd5;
            4'b0110:          y4 = 3'd6;
            4'b1110, 4'b0001: begin y4 = 3'd7; p7 = 1'b1; end
            4'b0111, 4'b1000: begin y4 = 3'd7; a7 = 1'b1; end
            default:          v4 = 1'b0;
        endcase
    end

    // 3b/4b decode following a K28 6b sub-block
    always_comb begin : deck
        ky = 3'd0;
        vk = 1'b1;
        case (c4)
            4'b0100, 4'b1011: ky = 3'd0;
            4'b1001:          ky = 3'd1;
            4'b0101:          ky = 3'd2;
            4'b0011, 4'b1100: ky = 3'd3;
            4'b0010, 4'b1101: ky = 3'd4;
            4'b1010:          ky = 3'd5;
            4'b0110:          ky = 3'd6;
            4'b1000, 4'b0111: ky = 3'd7;
            default:          vk = 1'b0;
        endcase
    end

    // Pair legality: A7/P7 choice is tied to the 6b group, A7 on x=23/27/29/30 means K
    always_comb begin : pairing
        grp_lo   = (x == 5'd17) || (x == 5'd18) || (x == 5'd20);
        grp_hi   = (x == 5'd11) || (x == 5'd13) || (x == 5'd14);
        grp_k    = (x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30);
        code_ok  = 1'b0;
        dec_byte = 8'h00;
        dec_k    = 1'b0;
        if (k28) begin
            code_ok  = vk;
            dec_byte = {ky, 5'd28};
            dec_k    = 1'b1;
        end else if (v6 && v4) begin
            if (p7) begin
                code_ok = grp_lo ? (s4 == 4'b0001) : (grp_hi ? (s4 == 4'b1110) : 1'b1);
            end else if (a7) begin
                code_ok = grp_lo ? (s4 == 4'b0111) : (grp_hi ? (s4 == 4'b1000) : grp_k);
            end else begin
                code_ok = 1'b1;
            end
            dec_byte = {y4, x};
            dec_k    = a7 && grp_k;
        end
        if (!code_ok) begin
            dec_byte = 8'h00;
            dec_k    = 1'b0;
        end
    end

    // Per-sub-block running disparity; sub-blocks beyond +/-2 leave rd alone
    always_comb begin : disparity
        e6  = 1'b0;
        rd1 = rd;
        if (ones6 == 3'd4)          begin e6 = rd;  rd1 = 1'b1; end
        else if (ones6 == 3'd2)     begin e6 = ~rd; rd1 = 1'b0; end
        else if (s6 == 6'b111000)   begin e6 = rd;  rd1 = 1'b0; end
        else if (s6 == 6'b000111)   begin e6 = ~rd; rd1 = 1'b1; end
        e4  = 1'b0;
        rd2 = rd1;
        if (ones4 == 3'd3)          begin e4 = rd1;  rd2 = 1'b1; end
        else if (ones4 == 3'd1)     begin e4 = ~rd1; rd2 = 1'b0; end
        else if (s4 == 4'b1100)     begin e4 = rd1;  rd2 = 1'b0; end
        else if (s4 == 4'b0011)     begin e4 = ~rd1; rd2 = 1'b1; end
        disp_err = e6 | e4;
    end

    // Sync FSM and next values of all output registers
    always_comb begin : fsm
        state_d   = state_q;
        cons_d    = cons_q;
        cnt_d     = cuentaErr;
        salidas_d = salidas;
        k_d       = K;
        rd_d      = rd;
        valido_d  = 1'b0;
        errc_d    = 1'b0;
        errd_d    = 1'b0;
        sym_err   = 1'b0;
        if (enb) begin
            salidas_d = dec_byte;
            k_d       = dec_k;
            errc_d    = ~code_ok;
            errd_d    = disp_err;
            sym_err   = ~code_ok | disp_err;
            if (code_ok) rd_d = rd2;
            case (state_q)
                DESINC: begin
                    if (comma) begin
                        state_d  = SINC;
                        cons_d   = '0;
                        valido_d = 1'b1;
                        errd_d   = 1'b0;
                    end
                end
                SINC: begin
                    valido_d = 1'b1;
                    if (sym_err) begin
                        if (cuentaErr != '1) cnt_d = cuentaErr + ERR_CNT_W'(1);
                        if ((cons_q + CONS_W'(1)) == CONS_W'(ERR_LIM)) begin
                            state_d  = DESINC;
                            valido_d = 1'b0;
                            cons_d   = '0;
                        end else begin
                            cons_d = cons_q + CONS_W'(1);
                        end
                    end else begin
                        cons_d = '0;
                    end
                end
                default: state_d = DESINC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= DESINC;
            cons_q        <= '0;
            cuentaErr     <= '0;
            salidas       <= 8'h00;
            K             <= 1'b0;
            valido        <= 1'b0;
            errCodigo     <= 1'b0;
            errDisparidad <= 1'b0;
            rd            <= 1'b0;
            sincronizado  <= 1'b0;
        end else begin
            state_q       <= state_d;
            cons_q        <= cons_d;
            cuentaErr     <= cnt_d;
            salidas       <= salidas_d;
            K             <= k_d;
            valido        <= valido_d;
            errCodigo     <= errc_d;
            errDisparidad <= errd_d;
            rd            <= rd_d;
            sincronizado  <= (state_d == SINC);
        end
    end
endmodule

// File: tb/tb_decoder_8b10b.sv
// Self-checking bench for decoder_8b10b: directed plan steps plus random symbols
// compared against an encoder-table search model.
module tb_decoder_8b10b;
    localparam int unsigned LIM = 4;
    localparam int unsigned CW  = 8;
    localparam logic [9:0] COMMA_N = 10'b0011111010;
    localparam logic [9:0] ZERO    = 10'b0000000000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enb = 1'b0;
    logic [9:0]    entradas = '0;
    logic [7:0]    salidas;
    logic          K, valido, errCodigo, errDisparidad, rd, sincronizado;
    logic [CW-1:0] cuentaErr;

    int checks = 0;
    int errors = 0;

    // reference state
    logic [7:0] m_salidas;
    bit         m_k, m_valido, m_errc, m_errd, m_rd, m_sync;
    int         m_cons, m_cnt;

    // RD- encoder forms
    logic [5:0] tab6 [0:31] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
        6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100,
        6'b011100, 6'b010111, 6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010,
        6'b011010, 6'b111010, 6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
        6'b011110, 6'b101011};
    logic [3:0] tab4 [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
    logic [3:0] tabk [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
    int         kx   [0:3] = '{23, 27, 29, 30};

    decoder_8b10b #(.ERR_LIM(LIM), .ERR_CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .enb(enb), .entradas(entradas), .salidas(salidas), .K(K),
        .valido(valido), .errCodigo(errCodigo), .errDisparidad(errDisparidad), .rd(rd),
        .sincronizado(sincronizado), .cuentaErr(cuentaErr));

    always #5 clk = ~clk;

    // symbol index: 0..255 data bytes, 256..263 K28.y, 264..267 K23/27/29/30.7
    function automatic void sym_xy(input int s, output int x, output int y, output bit isk);
        if (s < 256) begin x = s % 32; y = s / 32; isk = 1'b0; end
        else if (s < 264) begin x = 28; y = s - 256; isk = 1'b1; end
        else begin x = kx[s - 264]; y = 7; isk = 1'b1; end
    endfunction

    function automatic logic [5:0] enc6(input int x, input bit isk, input bit r);
        logic [5:0] b;
        b = (isk && x == 28) ? 6'b001111 : tab6[x];
        if (r && ($countones(b) != 3 || (x == 7 && !isk))) b = ~b;
        return b;
    endfunction

    function automatic bit rd_after6(input logic [5:0] f, input bit r);
        return ($countones(f) == 3) ? r : ~r;
    endfunction

    function automatic logic [3:0] enc4(input int x, input int y, input bit isk, input bit r6);
        logic [3:0] b;
        bit alt;
        if (isk) return r6 ? ~tabk[y] : tabk[y];
        alt = (y == 7) && ((!r6 && (x == 17 || x == 18 || x == 20)) ||
                           (r6 && (x == 11 || x == 13 || x == 14)));
        b = alt ? 4'b0111 : tab4[y];
        if (r6 && ($countones(b) != 2 || y == 3)) b = ~b;
        return b;
    endfunction

    function automatic logic [9:0] encode(input int s, input bit r);
        int x, y;
        bit isk;
        logic [5:0] f6;
        sym_xy(s, x, y, isk);
        f6 = enc6(x, isk, r);
        return {f6, enc4(x, y, isk, rd_after6(f6, r))};
    endfunction

    // Legal if some symbol's 6b and 4b forms both appear; polarity-consistent 4b preferred.
    function automatic void model_decode(input logic [9:0] c, output bit ok,
                                         output logic [7:0] b, output bit k);
        int x, y;
        bit isk, r6;
        logic [5:0] f6;
        logic [3:0] f4;
        ok = 1'b0; b = 8'h00; k = 1'b0;
        for (int pass = 0; pass < 2; pass++)
            for (int s = 0; s < 268; s++)
                for (int r = 0; r < 2; r++) begin
                    sym_xy(s, x, y, isk);
                    f6 = enc6(x, isk, r[0]);
                    if (!ok && f6 == c[9:4]) begin
                        r6 = rd_after6(f6, r[0]);
                        for (int r4 = 0; r4 < 2; r4++) begin
                            f4 = enc4(x, y, isk, r4[0]);
                            if (!ok && (pass == 1 || r4[0] == r6) && f4 == c[3:0]) begin
                                ok = 1'b1; b = 8'(y * 32 + x); k = isk;
                            end
                        end
                    end
                end
    endfunction

    // Generic sub-block disparity rule for width 6 or 4
    function automatic void sub_disp(input logic [5:0] bits, input int w, input bit rin,
                                     output bit err, output bit rout);
        int d;
        logic [5:0] top, bot;
        d   = 2 * $countones(bits) - w;
        bot = 6'((1 << (w / 2)) - 1);
        top = 6'(((1 << w) - 1) ^ ((1 << (w / 2)) - 1));
        err = 1'b0; rout = rin;
        if (d == 2)                         begin err = rin;  rout = 1'b1; end
        else if (d == -2)                   begin err = !rin; rout = 1'b0; end
        else if (d == 0 && bits == top)     begin err = rin;  rout = 1'b0; end
        else if (d == 0 && bits == bot)     begin err = !rin; rout = 1'b1; end
    endfunction

    function automatic void model_reset();
        m_salidas = 8'h00; m_k = 0; m_valido = 0; m_errc = 0; m_errd = 0;
        m_rd = 0; m_sync = 0; m_cons = 0; m_cnt = 0;
    endfunction

    function automatic void model_step(input bit e, input logic [9:0] c);
        bit ok, k, e6, e4, r1, r2, bad;
        logic [7:0] b;
        m_valido = 0; m_errc = 0; m_errd = 0;
        if (!e) return;
        model_decode(c, ok, b, k);
        sub_disp(c[9:4], 6, m_rd, e6, r1);
        sub_disp({2'b00, c[3:0]}, 4, r1, e4, r2);
        m_errc    = !ok;
        m_errd    = e6 | e4;
        m_salidas = ok ? b : 8'h00;
        m_k       = ok ? k : 1'b0;
        bad       = m_errc | m_errd;
        if (ok) m_rd = r2;
        if (!m_sync) begin
            if (ok && k && b == 8'hBC) begin
                m_sync = 1; m_cons = 0; m_valido = 1; m_errd = 0;
            end
        end else begin
            m_valido = 1;
            if (bad) begin
                if (m_cnt < (2 ** CW) - 1) m_cnt++;
                m_cons++;
                if (m_cons == LIM) begin m_sync = 0; m_valido = 0; m_cons = 0; end
            end else begin
                m_cons = 0;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".salidas"},       32'(salidas),       32'(m_salidas));
        chk({tag, ".K"},             32'(K),             32'(m_k));
        chk({tag, ".valido"},        32'(valido),        32'(m_valido));
        chk({tag, ".errCodigo"},     32'(errCodigo),     32'(m_errc));
        chk({tag, ".errDisparidad"}, 32'(errDisparidad), 32'(m_errd));
        chk({tag, ".rd"},            32'(rd),            32'(m_rd));
        chk({tag, ".sincronizado"},  32'(sincronizado),  32'(m_sync));
        chk({tag, ".cuentaErr"},     32'(cuentaErr),     32'(m_cnt));
    endtask

    task automatic step(input bit e, input logic [9:0] c, input string tag);
        enb = e; entradas = c;
        @(posedge clk); #1;
        model_step(e, c);
        check_all(tag);
    endtask

    task automatic do_reset(input bit e, input logic [9:0] c, input string tag);
        rst = 1'b1; enb = e; entradas = c;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        check_all(tag);
    endtask

    initial begin
        int kind;
        do_reset(1'b0, ZERO, "reset");
        // unsynced data, then comma acquisition
        step(1'b1, 10'b1001110100, "pre_comma0");
        chk("pre_comma_valido", 32'(valido), 32'd0);
        step(1'b1, 10'b1001110100, "pre_comma1");
        step(1'b1, COMMA_N, "comma");
        chk("comma_byte", 32'(salidas), 32'hBC);
        chk("comma_k", 32'(K), 32'd1);
        chk("comma_rd", 32'(rd), 32'd1);
        step(1'b1, 10'b0110001011, "d0_0_pos");
        chk("d0_0_byte", 32'(salidas), 32'h00);
        step(1'b1, 10'b1010101010, "d21_5");
        chk("d21_5_byte", 32'(salidas), 32'hB5);
        step(1'b1, 10'b1001110100, "d0_0_wrong_rd");
        chk("wrong_rd_flag", 32'(errDisparidad), 32'd1);
        chk("wrong_rd_cnt", 32'(cuentaErr), 32'd1);
        // ERR_LIM consecutive code errors drop sync; counter then frozen
        do_reset(1'b1, ZERO, "reset2");
        step(1'b1, COMMA_N, "comma2");
        for (int i = 0; i < int'(LIM); i++) step(1'b1, ZERO, "zeros");
        chk("drop_sync", 32'(sincronizado), 32'd0);
        chk("drop_cnt", 32'(cuentaErr), 32'(LIM));
        step(1'b1, ZERO, "zeros_after");
        step(1'b1, ZERO, "zeros_after");
        chk("frozen_cnt", 32'(cuentaErr), 32'(LIM));
        // 3 errors, good symbol, 3 errors: still synced
        do_reset(1'b0, ZERO, "reset3");
        step(1'b1, COMMA_N, "comma3");
        for (int i = 0; i < 3; i++) step(1'b1, ZERO, "err_a");
        step(1'b1, 10'b1010101010, "good_mid");
        for (int i = 0; i < 3; i++) step(1'b1, ZERO, "err_b");
        chk("six_sync", 32'(sincronizado), 32'd1);
        chk("six_cnt", 32'(cuentaErr), 32'd6);
        // enb gaps hold outputs
        step(1'b1, encode(261, m_rd), "gap_pre");
        step(1'b0, 10'b1111111111, "gap0");
        step(1'b1, encode(21 + 32 * 5, m_rd), "gap_mid");
        step(1'b0, ZERO, "gap1");
        do_reset(1'b1, COMMA_N, "rst_mid");
        // saturation of the error counter across resyncs
        for (int j = 0; j < 70; j++) begin
            step(1'b1, encode(261, m_rd), "sat_comma");
            for (int i = 0; i < int'(LIM); i++) step(1'b1, ZERO, "sat_err");
        end
        chk("sat_cnt", 32'(cuentaErr), 32'hFF);
        // randomized traffic
        do_reset(1'b0, ZERO, "reset4");
        for (int n = 0; n < 600; n++) begin
            kind = int'($urandom_range(0, 99));
            if (kind < 8)       step(1'b0, 10'($urandom), "rnd_idle");
            else if (kind < 10) do_reset(1'($urandom), 10'($urandom), "rnd_reset");
            else if (kind < 55) step(1'b1, encode(int'($urandom_range(0, 267)), m_rd), "rnd_legal");
            else if (kind < 65) step(1'b1, encode(int'($urandom_range(0, 267)), !m_rd), "rnd_wrongrd");
            else if (kind < 72) step(1'b1, encode(261, m_rd), "rnd_comma");
            else                step(1'b1, 10'($urandom), "rnd_raw");
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
